// File: rtl/flag_pkg.sv
// Shared types and default sizes for the ALU flag status unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package flag_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 8;

    // Condition selector used by the sequencer when querying the flags.
    typedef enum logic [2:0] {
        ALWAYS = 3'd0,
        EQ     = 3'd1,
        NE     = 3'd2,
        NEG    = 3'd3,
        POS    = 3'd4,
        NONNEG = 3'd5,
        STZ    = 3'd6,
        STS    = 3'd7
    } cond_e;

    // IDLE: no response outstanding; HOLD: response presented on resp_*.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } resp_state_e;

endpackage

// File: rtl/flag_status_unit_cond_eval.sv
// Maps a condition code plus the live and sticky flags to a taken bit.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed by the response FSM.
//
// Ports: cond_code (selector), flag_z/flag_s (registered flags),
//        sticky_z/sticky_s (sticky flags), taken (condition result).
module cond_eval
    import flag_pkg::*;
(
    input  logic [2:0] cond_code,
    input  logic       flag_z,
    input  logic       flag_s,
    input  logic       sticky_z,
    input  logic       sticky_s,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond_e'(cond_code))
            ALWAYS: taken = 1'b1;
            EQ:     taken = flag_z;
            NE:     taken = ~flag_z;
            NEG:    taken = flag_s;
            POS:    taken = ~flag_s & ~flag_z;
            NONNEG: taken = ~flag_s;
            STZ:    taken = sticky_z;
            STS:    taken = sticky_s;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_status_unit.sv
// Registers ALU result/flags, keeps sticky flags and a capture count, answers condition queries.
// Latency: capture 1 cycle; query response 1 cycle after accept, back-to-back supported.
// Backpressure: cond_ready drops while a response is held and resp_ready is low.
//
// Ports: clk/rst_n (async active-low reset); in_valid/in_result/in_zero/in_sign
//        (capture path); sticky_clr (clears sticky flags, counter, error);
//        cond_valid/cond_code/cond_ready (query); resp_valid/resp_taken/resp_ready
//        (response); flag_z/flag_s/sticky_z/sticky_s/result_q/cap_cnt (status);
//        flag_err (flag consistency error).
// Optional: define FLAG_CHECK_EN to build the flag consistency checker;
//           otherwise flag_err is tied low.
module flag_status_unit
    import flag_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_zero,
    input  logic             in_sign,
    input  logic             sticky_clr,
    input  logic             cond_valid,
    input  logic [2:0]       cond_code,
    output logic             cond_ready,
    output logic             resp_valid,
    output logic             resp_taken,
    input  logic             resp_ready,
    output logic             flag_z,
    output logic             flag_s,
    output logic             sticky_z,
    output logic             sticky_s,
    output logic [WIDTH-1:0] result_q,
    output logic [CNT_W-1:0] cap_cnt,
    output logic             flag_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    resp_state_e state, state_nxt;
    logic        taken_nxt;
    logic        eval_taken;
    logic        accept;

    // ------------------------------------------------------------------
    // Capture path: live flags and result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z   <= 1'b0;
            flag_s   <= 1'b0;
            result_q <= '0;
        end else if (in_valid) begin
            flag_z   <= in_zero;
            flag_s   <= in_sign;
            result_q <= in_result;
        end
    end

    // Sticky flags and saturating counter. A clear coinciding with a capture
    // acts as clear-then-capture, so the capture is counted and its flags kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_z <= 1'b0;
            sticky_s <= 1'b0;
            cap_cnt  <= '0;
        end else if (sticky_clr) begin
            sticky_z <= in_valid & in_zero;
            sticky_s <= in_valid & in_sign;
            cap_cnt  <= in_valid ? CNT_W'(1) : '0;
        end else if (in_valid) begin
            sticky_z <= sticky_z | in_zero;
            sticky_s <= sticky_s | in_sign;
            if (cap_cnt != CNT_MAX) begin
                cap_cnt <= cap_cnt + 1'b1;
            end
        end
    end

`ifdef FLAG_CHECK_EN
    // Recompute the flags from the result and flag any disagreement with the
    // flag generators. Same clear-then-capture ordering as the sticky flags.
    logic flag_mismatch;

    assign flag_mismatch = in_valid &
                           (((in_result == '0) != in_zero) ||
                            (in_result[WIDTH-1] != in_sign));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_err <= 1'b0;
        end else if (sticky_clr) begin
            flag_err <= flag_mismatch;
        end else if (flag_mismatch) begin
            flag_err <= 1'b1;
        end
    end
`else
    assign flag_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Condition query / response
    // ------------------------------------------------------------------
    // Evaluation uses the registered flags, so a capture in the accept cycle
    // is not visible to that query.
    cond_eval u_cond_eval (
        .cond_code (cond_code),
        .flag_z    (flag_z),
        .flag_s    (flag_s),
        .sticky_z  (sticky_z),
        .sticky_s  (sticky_s),
        .taken     (eval_taken)
    );

    assign cond_ready = (state == IDLE) | resp_ready;
    assign accept     = cond_valid & cond_ready;
    assign resp_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            resp_taken <= 1'b0;
        end else begin
            state      <= state_nxt;
            resp_taken <= taken_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        taken_nxt = resp_taken;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = HOLD;
                    taken_nxt = eval_taken;
                end
            end
            HOLD: begin
                if (resp_ready) begin
                    if (accept) begin
                        state_nxt = HOLD;
                        taken_nxt = eval_taken;
                    end else begin
                        state_nxt = IDLE;
                        taken_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                taken_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_flag_status_unit.sv
// Self-checking bench for flag_status_unit: directed vector table, reset and
// saturation sequences, then randomized traffic against a reference model.
module tb_flag_status_unit;
    import flag_pkg::*;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_result;
    logic             in_zero;
    logic             in_sign;
    logic             sticky_clr;
    logic             cond_valid;
    logic [2:0]       cond_code;
    logic             cond_ready;
    logic             resp_valid;
    logic             resp_taken;
    logic             resp_ready;
    logic             flag_z;
    logic             flag_s;
    logic             sticky_z;
    logic             sticky_s;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cap_cnt;
    logic             flag_err;

    flag_status_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_result  (in_result),
        .in_zero    (in_zero),
        .in_sign    (in_sign),
        .sticky_clr (sticky_clr),
        .cond_valid (cond_valid),
        .cond_code  (cond_code),
        .cond_ready (cond_ready),
        .resp_valid (resp_valid),
        .resp_taken (resp_taken),
        .resp_ready (resp_ready),
        .flag_z     (flag_z),
        .flag_s     (flag_s),
        .sticky_z   (sticky_z),
        .sticky_s   (sticky_s),
        .result_q   (result_q),
        .cap_cnt    (cap_cnt),
        .flag_err   (flag_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    bit             m_fz, m_fs, m_sz, m_ss, m_err;
    bit [WIDTH-1:0] m_res;
    int             m_cnt;
    bit             m_pend;   // a response is outstanding
    bit             m_taken;

    task automatic model_reset();
        m_fz = 0; m_fs = 0; m_sz = 0; m_ss = 0; m_err = 0;
        m_res = '0; m_cnt = 0; m_pend = 0; m_taken = 0;
    endtask

    function automatic bit model_eval(input logic [2:0] c);
        bit [7:0] t;
        t = {m_ss, m_sz, ~m_fs, ~m_fs & ~m_fz, m_fs, ~m_fz, m_fz, 1'b1};
        return t[c];
    endfunction

    // Applies one clock edge worth of the current inputs to the model.
    task automatic model_step();
        bit acc;
        bit mism;
        acc = cond_valid && (!m_pend || resp_ready);
        if (acc) begin
            m_taken = model_eval(cond_code);
            m_pend  = 1;
        end else if (m_pend && resp_ready) begin
            m_pend  = 0;
            m_taken = 0;
        end
        if (sticky_clr) begin
            m_sz = 0; m_ss = 0; m_cnt = 0; m_err = 0;
        end
        if (in_valid) begin
            mism  = ((in_result == 0) != in_zero) || (in_result[WIDTH-1] != in_sign);
            m_fz  = in_zero;
            m_fs  = in_sign;
            m_res = in_result;
            m_sz  = m_sz | in_zero;
            m_ss  = m_ss | in_sign;
            m_cnt = (m_cnt + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_cnt + 1;
`ifdef FLAG_CHECK_EN
            if (mism) m_err = 1;
`endif
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_resp_valid", 32'(resp_valid), 32'(m_pend));
        chk("m_resp_taken", 32'(resp_taken), 32'(m_taken));
        chk("m_cond_ready", 32'(cond_ready), 32'(!m_pend || resp_ready));
        chk("m_flag_z",     32'(flag_z),     32'(m_fz));
        chk("m_flag_s",     32'(flag_s),     32'(m_fs));
        chk("m_sticky_z",   32'(sticky_z),   32'(m_sz));
        chk("m_sticky_s",   32'(sticky_s),   32'(m_ss));
        chk("m_result_q",   32'(result_q),   32'(m_res));
        chk("m_cap_cnt",    32'(cap_cnt),    32'(m_cnt));
        chk("m_flag_err",   32'(flag_err),   32'(m_err));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_result = '0; in_zero = 0; in_sign = 0;
        sticky_clr = 0; cond_valid = 0; cond_code = 3'd0; resp_ready = 1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic             v;
        logic [WIDTH-1:0] res;
        logic             z, s, clr, cv;
        logic [2:0]       code;
        logic             rr;
        logic             e_rv, e_tk, e_crdy, e_fz, e_fs, e_sz, e_ss;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            v  res       z  s  clr cv code     rr | rv tk crdy fz fs sz ss cnt
        tbl[0]  = '{1, 16'h0000, 1, 0, 0, 0, 3'(ALWAYS), 1,  0, 0, 1,  1, 0, 1, 0, 8'd1};
        tbl[1]  = '{0, 16'h0000, 0, 0, 0, 1, 3'(EQ),     1,  1, 1, 1,  1, 0, 1, 0, 8'd1};
        tbl[2]  = '{0, 16'h0000, 0, 0, 0, 1, 3'(POS),    1,  1, 0, 1,  1, 0, 1, 0, 8'd1};
        tbl[3]  = '{0, 16'h0000, 0, 0, 0, 0, 3'(ALWAYS), 1,  0, 0, 1,  1, 0, 1, 0, 8'd1};
        tbl[4]  = '{1, 16'h8001, 0, 1, 1, 0, 3'(ALWAYS), 1,  0, 0, 1,  0, 1, 0, 1, 8'd1};
        tbl[5]  = '{1, 16'h0005, 0, 0, 0, 0, 3'(ALWAYS), 1,  0, 0, 1,  0, 0, 0, 1, 8'd2};
        tbl[6]  = '{0, 16'h0000, 0, 0, 0, 1, 3'(STS),    1,  1, 1, 1,  0, 0, 0, 1, 8'd2};
        tbl[7]  = '{0, 16'h0000, 0, 0, 0, 1, 3'(NEG),    1,  1, 0, 1,  0, 0, 0, 1, 8'd2};
        tbl[8]  = '{1, 16'h0000, 1, 0, 0, 1, 3'(EQ),     1,  1, 0, 1,  1, 0, 1, 1, 8'd3};
        tbl[9]  = '{0, 16'h0000, 0, 0, 0, 1, 3'(EQ),     1,  1, 1, 1,  1, 0, 1, 1, 8'd3};
        tbl[10] = '{0, 16'h0000, 0, 0, 0, 1, 3'(NE),     1,  1, 0, 1,  1, 0, 1, 1, 8'd3};
        tbl[11] = '{0, 16'h0000, 0, 0, 0, 1, 3'(ALWAYS), 0,  1, 0, 0,  1, 0, 1, 1, 8'd3};
        tbl[12] = '{0, 16'h0000, 0, 0, 0, 1, 3'(ALWAYS), 0,  1, 0, 0,  1, 0, 1, 1, 8'd3};
        tbl[13] = '{0, 16'h0000, 0, 0, 0, 1, 3'(ALWAYS), 0,  1, 0, 0,  1, 0, 1, 1, 8'd3};
        tbl[14] = '{0, 16'h0000, 0, 0, 0, 1, 3'(ALWAYS), 1,  1, 1, 1,  1, 0, 1, 1, 8'd3};
        tbl[15] = '{0, 16'h0000, 0, 0, 0, 1, 3'(NEG),    1,  1, 0, 1,  1, 0, 1, 1, 8'd3};
        tbl[16] = '{0, 16'h0000, 0, 0, 0, 1, 3'(NONNEG), 1,  1, 1, 1,  1, 0, 1, 1, 8'd3};
        tbl[17] = '{0, 16'h0000, 0, 0, 0, 1, 3'(STZ),    1,  1, 1, 1,  1, 0, 1, 1, 8'd3};
        tbl[18] = '{0, 16'h0000, 0, 0, 0, 0, 3'(ALWAYS), 1,  0, 0, 1,  1, 0, 1, 1, 8'd3};
        tbl[19] = '{0, 16'h0000, 0, 0, 1, 0, 3'(ALWAYS), 1,  0, 0, 1,  1, 0, 0, 0, 8'd0};

        // ---------------- reset ----------------
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        check_model();
        chk("reset_cond_ready", 32'(cond_ready), 32'd1);
        chk("reset_cap_cnt",    32'(cap_cnt),    32'd0);

        // ---------------- directed table ----------------
        for (int i = 0; i < NV; i++) begin
            in_valid   = tbl[i].v;
            in_result  = tbl[i].res;
            in_zero    = tbl[i].z;
            in_sign    = tbl[i].s;
            sticky_clr = tbl[i].clr;
            cond_valid = tbl[i].cv;
            cond_code  = tbl[i].code;
            resp_ready = tbl[i].rr;
            cycle();
            chk($sformatf("tbl%0d_resp_valid", i), 32'(resp_valid), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_resp_taken", i), 32'(resp_taken), 32'(tbl[i].e_tk));
            chk($sformatf("tbl%0d_cond_ready", i), 32'(cond_ready), 32'(tbl[i].e_crdy));
            chk($sformatf("tbl%0d_flag_z", i),     32'(flag_z),     32'(tbl[i].e_fz));
            chk($sformatf("tbl%0d_flag_s", i),     32'(flag_s),     32'(tbl[i].e_fs));
            chk($sformatf("tbl%0d_sticky_z", i),   32'(sticky_z),   32'(tbl[i].e_sz));
            chk($sformatf("tbl%0d_sticky_s", i),   32'(sticky_s),   32'(tbl[i].e_ss));
            chk($sformatf("tbl%0d_cap_cnt", i),    32'(cap_cnt),    32'(tbl[i].e_cnt));
        end
        idle_inputs();

        // ---------------- counter saturation ----------------
        for (int i = 0; i < 256; i++) begin
            in_valid  = 1;
            in_result = 16'(i + 1);
            in_zero   = 0;
            in_sign   = 0;
            cycle();
        end
        chk("sat_cap_cnt", 32'(cap_cnt), 32'd255);
        in_result  = 16'h0000;
        in_zero    = 1;
        sticky_clr = 1;
        cycle();
        chk("clr_cap_cap_cnt",  32'(cap_cnt),  32'd1);
        chk("clr_cap_sticky_z", 32'(sticky_z), 32'd1);
        idle_inputs();

        // ---------------- flag consistency ----------------
        in_valid  = 1;
        in_result = 16'h0003;
        in_zero   = 1;
        cycle();
        idle_inputs();
`ifdef FLAG_CHECK_EN
        chk("flag_err_set", 32'(flag_err), 32'd1);
`else
        chk("flag_err_tied", 32'(flag_err), 32'd0);
`endif
        cycle();
        sticky_clr = 1;
        cycle();
        idle_inputs();
        chk("flag_err_clr", 32'(flag_err), 32'd0);

        // ---------------- reset while holding a response ----------------
        cond_valid = 1;
        cond_code  = 3'(ALWAYS);
        resp_ready = 0;
        in_valid   = 1;
        in_result  = 16'h8000;
        in_sign    = 1;
        cycle();
        in_valid   = 0;
        cond_valid = 0;
        cycle();
        chk("hold_resp_valid", 32'(resp_valid), 32'd1);
        chk("hold_resp_taken", 32'(resp_taken), 32'd1);
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_taken", 32'(resp_taken), 32'd0);
        chk("rst_flag_s",     32'(flag_s),     32'd0);
        chk("rst_sticky_s",   32'(sticky_s),   32'd0);
        chk("rst_result_q",   32'(result_q),   32'd0);
        chk("rst_cap_cnt",    32'(cap_cnt),    32'd0);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        check_model();
        chk("rst_release_cond_ready", 32'(cond_ready), 32'd1);

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 2000; n++) begin
            int sel;
            in_valid = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            if (sel == 0)      in_result = '0;
            else if (sel == 1) in_result = 16'h8000 | 16'($urandom);
            else               in_result = 16'($urandom);
            in_zero = (in_result == 0);
            in_sign = in_result[WIDTH-1];
            if ($urandom_range(0, 15) == 0) in_zero = ~in_zero;
            if ($urandom_range(0, 15) == 0) in_sign = ~in_sign;
            sticky_clr = ($urandom_range(0, 15) == 0);
            cond_valid = 1'($urandom_range(0, 1));
            cond_code  = 3'($urandom_range(0, 7));
            resp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
